// File: rtl/d_pop_arbiter.sv
// d_pop_arbiter: round-robin merge of two FIFOs with 2-cycle pop-to-valid latency and a 1-entry skid; POP_COUNT_EN adds per-source transfer counters
module d_pop_arbiter #(
    parameter int data_width = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  empty_fifo_D0,
    input  logic                  empty_fifo_D1,
    input  logic [data_width-1:0] data_out_D0,
    input  logic [data_width-1:0] data_out_D1,
    input  logic                  ready_out,
    output logic                  D0_pop,
    output logic                  D1_pop,
    output logic [data_width-1:0] data_out,
    output logic                  valid_out,
    output logic                  src_out,
    output logic                  idle_out,
    output logic [7:0]            cnt_D0,
    output logic [7:0]            cnt_D1
);
    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    state_t                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  fly_q, fly_d, fly_src_q, fly_src_d;
    logic                  skid_vld_q, skid_vld_d, skid_src_q, skid_src_d;
    logic [data_width-1:0] skid_data_q, skid_data_d, data_q, data_d;
    logic                  valid_q, valid_d, src_q, src_d;
    logic                  can_pop, out_free;
    logic [data_width-1:0] fly_data;

    // Pop grant: ptr_q is the source preferred next; pops only when the whole path can absorb the word
    always_comb begin
        can_pop = reset & enable & ready_out & ~skid_vld_q;
        D0_pop  = can_pop & ~empty_fifo_D0 & (empty_fifo_D1 | ~ptr_q);
        D1_pop  = can_pop & ~empty_fifo_D1 & (empty_fifo_D0 | ptr_q);
        ptr_d   = (D0_pop | D1_pop) ? D0_pop : ptr_q;
        fly_d   = D0_pop | D1_pop;
        fly_src_d = D1_pop;
    end

    // Output path: skid drains first; an arriving word parks in the skid if the output is held
    always_comb begin
        fly_data    = fly_src_q ? data_out_D1 : data_out_D0;
        out_free    = ~valid_q | ready_out;
        data_d      = data_q;
        valid_d     = valid_q;
        src_d       = src_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_src_d  = skid_src_q;
        if (out_free) begin
            if (skid_vld_q) begin
                data_d     = skid_data_q;
                src_d      = skid_src_q;
                valid_d    = 1'b1;
                skid_vld_d = 1'b0;
            end else if (fly_q) begin
                data_d  = fly_data;
                src_d   = fly_src_q;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end else if (fly_q) begin
            skid_vld_d  = 1'b1;
            skid_data_d = fly_data;
            skid_src_d  = fly_src_q;
        end
    end

    // Control FSM: tracks activity for idle reporting
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable & ~(empty_fifo_D0 & empty_fifo_D1)) state_d = RUN;
            RUN:     if (~ready_out & valid_q) state_d = STALL;
                     else if ((~enable | (empty_fifo_D0 & empty_fifo_D1)) & ~fly_q & ~skid_vld_q) state_d = IDLE;
            STALL:   if (ready_out & ~skid_vld_q) state_d = RUN;
            default: state_d = IDLE;
        endcase
        idle_out = (state_q == IDLE) & ~skid_vld_q & ~valid_q & ~fly_q;
    end

    // State registers; reset also drops any word still in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            fly_q       <= 1'b0;
            fly_src_q   <= 1'b0;
            skid_vld_q  <= 1'b0;
            skid_src_q  <= 1'b0;
            skid_data_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            src_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            fly_q       <= fly_d;
            fly_src_q   <= fly_src_d;
            skid_vld_q  <= skid_vld_d;
            skid_src_q  <= skid_src_d;
            skid_data_q <= skid_data_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            src_q       <= src_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign src_out   = src_q;

`ifdef POP_COUNT_EN
    logic [7:0] cnt_d0_q, cnt_d0_d, cnt_d1_q, cnt_d1_d;

    // Per-source completed-transfer counters, wrapping at 256
    always_comb begin
        cnt_d0_d = cnt_d0_q + 8'(valid_q & ready_out & ~src_q);
        cnt_d1_d = cnt_d1_q + 8'(valid_q & ready_out & src_q);
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_d0_q <= '0;
            cnt_d1_q <= '0;
        end else begin
            cnt_d0_q <= cnt_d0_d;
            cnt_d1_q <= cnt_d1_d;
        end
    end

    assign cnt_D0 = cnt_d0_q;
    assign cnt_D1 = cnt_d1_q;
`else
    assign cnt_D0 = '0;
    assign cnt_D1 = '0;
`endif
endmodule

// File: tb/tb_d_pop_arbiter.sv
// tb_d_pop_arbiter: randomized scoreboard bench for d_pop_arbiter with FIFO models and a round-robin reference
module tb_d_pop_arbiter;
    localparam int W = 6;
`ifdef POP_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0, enable = 1'b0, ready_out = 1'b0;
    logic         empty_fifo_D0 = 1'b1, empty_fifo_D1 = 1'b1;
    logic [W-1:0] data_out_D0 = '0, data_out_D1 = '0;
    logic         D0_pop, D1_pop, valid_out, src_out, idle_out;
    logic [W-1:0] data_out;
    logic [7:0]   cnt_D0, cnt_D1;
    logic         pop0_q = 1'b0, pop1_q = 1'b0;

    int           vectors = 0, miscompares = 0;
    logic [W-1:0] q0[$], q1[$];
    logic [W:0]   exp_q[$];
    logic         pref = 1'b0, hold_v = 1'b0;
    logic [W:0]   hold_w = '0;
    int           mc0 = 0, mc1 = 0;

    logic [5:0]   pv, p1v, vv, sv;
    logic [W-1:0] dv[6];
    logic [5:0]   seq;
    logic [11:0]  vv2;
    int           npop;
    logic [W:0]   held;

    d_pop_arbiter #(.data_width(W)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .empty_fifo_D0(empty_fifo_D0), .empty_fifo_D1(empty_fifo_D1),
        .data_out_D0(data_out_D0), .data_out_D1(data_out_D1),
        .ready_out(ready_out), .D0_pop(D0_pop), .D1_pop(D1_pop),
        .data_out(data_out), .valid_out(valid_out), .src_out(src_out),
        .idle_out(idle_out), .cnt_D0(cnt_D0), .cnt_D1(cnt_D1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pop0_q <= D0_pop;
        pop1_q <= D1_pop;
    end

    function automatic logic [7:0] cexp(input int n);
        return CNT_ON ? 8'(n) : 8'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (pop0_q && q0.size() > 0) data_out_D0 = q0.pop_front();
        if (pop1_q && q1.size() > 0) data_out_D1 = q1.pop_front();
        empty_fifo_D0 = (q0.size() == 0);
        empty_fifo_D1 = (q1.size() == 0);
    endtask

    task automatic push(input bit s, input logic [W-1:0] v);
        if (s) begin
            q1.push_back(v);
            empty_fifo_D1 = 1'b0;
        end else begin
            q0.push_back(v);
            empty_fifo_D0 = 1'b0;
        end
    endtask

    task automatic rst_seq();
        reset = 1'b0;
        q0.delete();
        q1.delete();
        empty_fifo_D0 = 1'b1;
        empty_fifo_D1 = 1'b1;
        tick();
        #4;
        chk("rst_data", data_out, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_src", src_out, 0);
        chk("rst_pops", {D0_pop, D1_pop}, 0);
        chk("rst_cnt", {cnt_D0, cnt_D1}, 0);
        chk("rst_idle", idle_out, 1);
        tick();
        reset = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        do begin
            tick();
            #4;
            n++;
        end while (!(q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && idle_out) && n < budget);
        chk({name, "_drain_timeout"}, n < budget, 1);
    endtask

    task automatic monitor();
        logic [W:0] w;
        logic       want_s;
        forever begin
            @(negedge clk);
            #3;
            if (!reset) begin
                chk("pop_in_reset", {D0_pop, D1_pop}, 0);
                exp_q.delete();
                pref   = 1'b0;
                hold_v = 1'b0;
                mc0    = 0;
                mc1    = 0;
            end else begin
                if (hold_v) chk("hold_stable", {valid_out, src_out, data_out}, {1'b1, hold_w});
                if (D0_pop || D1_pop) begin
                    chk("pop_one_hot", D0_pop & D1_pop, 0);
                    chk("pop_allowed", enable & ready_out, 1);
                    want_s = (q0.size() > 0 && q1.size() > 0) ? pref : (q0.size() == 0);
                    chk("rr_src", D1_pop, want_s);
                    if ((D1_pop ? q1.size() : q0.size()) == 0) chk("pop_while_empty", 1, 0);
                    else exp_q.push_back({D1_pop, D1_pop ? q1[0] : q0[0]});
                    pref = ~D1_pop;
                end
                if (valid_out && ready_out) begin
                    if (exp_q.size() == 0) chk("spurious_word", {src_out, data_out}, 32'hffff);
                    else begin
                        w = exp_q.pop_front();
                        chk("word", {src_out, data_out}, w);
                        if (w[W]) mc1++;
                        else mc0++;
                    end
                end
                hold_v = valid_out & ~ready_out;
                hold_w = {src_out, data_out};
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        ready_out = 1'b1;
        rst_seq();

        // both FIFOs empty with enable high: no pops, idle throughout
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            #4;
            chk("empty_pops", {D0_pop, D1_pop}, 0);
            chk("empty_idle", idle_out, 1);
        end

        // two preloaded D0 words: back-to-back pops, each word two cycles later
        tick();
        enable = 1'b0;
        push(0, 6'b001000);
        push(0, 6'b010101);
        tick();
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            #4;
            pv[i] = D0_pop; p1v[i] = D1_pop; vv[i] = valid_out; sv[i] = src_out; dv[i] = data_out;
        end
        chk("pre_d0_pops", pv, 6'b000011);
        chk("pre_d1_pops", p1v, 0);
        chk("pre_valid", vv, 6'b001100);
        chk("pre_word0", dv[2], 6'b001000);
        chk("pre_word1", dv[3], 6'b010101);
        chk("pre_src", sv[2] | sv[3], 0);
        chk("pre_idle", idle_out, 1);

        // three words each: strict alternation from D0, six consecutive valid cycles
        tick();
        rst_seq();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(0, W'($urandom));
            push(1, W'($urandom));
        end
        seq = '0; vv2 = '0; npop = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            #4;
            if ((D0_pop || D1_pop) && npop < 6) begin
                seq[npop] = D1_pop;
                npop++;
            end
            vv2[i] = valid_out;
        end
        chk("rr_npops", npop, 6);
        chk("rr_order", seq, 6'b101010);
        chk("rr_valid_run", vv2, 12'b0000_1111_1100);

        // output stall of three cycles mid-stream
        tick();
        for (int i = 0; i < 8; i++) push(0, W'(i + 40));
        repeat (3) tick();
        ready_out = 1'b0;
        #4;
        held = {src_out, data_out};
        chk("stall_valid", valid_out, 1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                tick();
                #4;
            end
            chk("stall_pops", {D0_pop, D1_pop}, 0);
            chk("stall_hold", {src_out, data_out}, held);
        end
        tick();
        ready_out = 1'b1;
        drain("stall", 100);

        // enable dropped with a word in flight
        tick();
        for (int i = 0; i < 6; i++) push(0, W'(i + 10));
        tick();
        tick();
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            #4;
            chk("noen_pops", {D0_pop, D1_pop}, 0);
        end
        chk("noen_idle", idle_out, 1);
        chk("noen_delivered", exp_q.size(), 0);
        chk("noen_left", q0.size(), 4);
        tick();
        enable = 1'b1;
        drain("noen", 100);

        // randomized traffic with back-pressure and enable gaps
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 3) == 0) push(0, W'($urandom));
            if ($urandom_range(0, 3) == 0) push(1, W'($urandom));
            ready_out = ($urandom_range(0, 9) < 7);
            enable = ($urandom_range(0, 19) != 0);
        end
        tick();
        ready_out = 1'b1;
        enable = 1'b1;
        drain("rand", 2000);
        tick();
        #4;
        chk("rand_cnt_d0", cnt_D0, cexp(mc0));
        chk("rand_cnt_d1", cnt_D1, cexp(mc1));

        // reset mid-stream discards everything in flight
        tick();
        for (int i = 0; i < 4; i++) begin
            push(0, W'($urandom));
            push(1, W'($urandom));
        end
        repeat (3) tick();
        rst_seq();
        for (int i = 0; i < 5; i++) begin
            tick();
            #4;
            chk("post_rst_valid", valid_out, 0);
        end

        // 260 words from D1: counters wrap
        tick();
        for (int i = 0; i < 260; i++) push(1, W'(i));
        drain("cnt", 400);
        tick();
        #4;
        chk("cnt_d1_260", cnt_D1, cexp(260));
        chk("cnt_d0_0", cnt_D0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/d_pop_arbiter.md
D_POP_ARBITER -- requirements
Module: d_pop_arbiter

Interface
REQ-001 SHALL have parameter: data_width, 6, word width of D0/D1 FIFO entries and of the output stream.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  arbiter permitted to pop (driven from full_logic active_out).
- empty_fifo_D0  input  1  D0 FIFO empty.
- empty_fifo_D1  input  1  D1 FIFO empty.
- data_out_D0  input  data_width  D0 FIFO read data.
- data_out_D1  input  data_width  D1 FIFO read data.
- ready_out  input  1  downstream accepts data_out this cycle.
- D0_pop  output  1  pop request to D0 FIFO.
- D1_pop  output  1  pop request to D1 FIFO.
- data_out  output  data_width  merged output word.
- valid_out  output  1  data_out holds a valid word.
- src_out  output  1  source of data_out (0 = D0, 1 = D1).
- idle_out  output  1  FSM in IDLE with nothing in flight.
- cnt_D0  output  8  words delivered from D0.
- cnt_D1  output  8  words delivered from D1.

Function
REQ-003 SHALL treat FIFO read timing as: Dx_pop high in cycle n -> popped word valid on data_out_Dx during cycle n+1 only.
REQ-004 SHALL drive D0_pop/D1_pop combinationally from registered state, ready_out, enable and the empty flags; at most one pop per cycle.
REQ-005 SHALL never assert Dx_pop while empty_fifo_Dx = 1.
REQ-006 SHALL register the word arriving in cycle n+1 into data_out with valid_out = 1 and src_out set in cycle n+2 (pop-to-valid latency 2).
REQ-007 SHALL arbitrate round-robin: one-bit last-served pointer; both non-empty -> grant the source not last served; one non-empty -> grant it; pointer updates only on a pop.
REQ-008 SHALL hold data_out/src_out/valid_out stable while valid_out = 1 and ready_out = 0; a word transfers when valid_out & ready_out are high at the clock edge.
REQ-009 SHALL capture the in-flight word into a 1-entry skid register when ready_out is low in its arrival cycle; skid drains to data_out before any new FIFO data.
REQ-010 SHALL suppress pops while ready_out = 0, while the skid is occupied, or while enable = 0.
REQ-011 SHALL sustain one word per cycle with ready_out = 1 and a non-empty FIFO.
REQ-012 FSM states: IDLE, RUN, STALL. Transitions: IDLE->RUN when enable = 1 and any FIFO non-empty; RUN->STALL when ready_out = 0 with valid_out = 1; STALL->RUN when ready_out = 1 and skid empty; RUN->IDLE when enable = 0 or both FIFOs empty, with no word in flight and skid empty.
REQ-013 SHALL deliver in-flight and skid words after enable drops mid-stream; no further pops until enable = 1.
REQ-014 SHALL assert idle_out only in IDLE with skid empty, valid_out = 0 and no pop outstanding.

Reset
REQ-015 SHALL, when reset = 0 at a rising edge: FSM -> IDLE, pointer -> 0 (D0 served first), skid cleared, data_out = 0, valid_out = 0, src_out = 0, cnt_D0 = cnt_D1 = 0.
REQ-016 SHALL keep D0_pop = D1_pop = 0 while reset = 0.
REQ-017 SHALL discard any in-flight word when reset is applied mid-operation.

Configuration
REQ-018 Macro POP_COUNT_EN defined: cnt_D0/cnt_D1 increment by 1 on each completed transfer from that source and wrap 255 -> 0.
REQ-019 Macro POP_COUNT_EN undefined: cnt_D0/cnt_D1 tied to 0 and no counter logic is synthesized; all other behaviour is identical.

Verification
REQ-020 After reset, D0 preloaded with 6'b001000, 6'b010101, D1 empty, enable = 1, ready_out = 1 -> D0_pop high for 2 consecutive cycles; data_out = 6'b001000 then 6'b010101, src_out = 0, 2 cycles after each pop.
REQ-021 Both FIFOs each holding 3 words, ready_out = 1 -> pops alternate D0, D1, D0, D1, D0, D1; valid_out high 6 consecutive cycles.
REQ-022 ready_out held 0 for 3 cycles mid-stream -> data_out held, exactly one word in skid, no pops; after release, skid word appears next with no loss or duplication.
REQ-023 enable dropped with a word in flight -> that word delivered, no further pops, idle_out = 1 once drained.
REQ-024 Both FIFOs empty, enable = 1 -> D0_pop = D1_pop = 0 and idle_out = 1 throughout; reset asserted mid-stream -> all outputs zero on the next cycle.
REQ-025 With POP_COUNT_EN, 260 words from D1 -> cnt_D1 = 4, cnt_D0 = 0; without the macro both read 0.
